// File: rtl/fp16_mac_feeder.sv
// fp16_mac_feeder: collects an 8-word frame (4 activations, 4 weights) for an
// external combinational FP16 MAC, holds the operands stable for SETTLE_CYCLES,
// samples the MAC result (optionally through ReLU) and offers it downstream with
// a valid/ready handshake.
`timescale 1ns/1ps

module fp16_mac_feeder #(
    parameter int unsigned SETTLE_CYCLES = 1,   // 1..15
    parameter bit          RELU_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mac_in0,
    output logic [15:0] mac_in1,
    output logic [15:0] mac_in2,
    output logic [15:0] mac_in3,
    output logic [15:0] mac_w0,
    output logic [15:0] mac_w1,
    output logic [15:0] mac_w2,
    output logic [15:0] mac_w3,
    input  logic [15:0] mac_result,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Settle counter value on the final SETTLE cycle.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  word_cnt;
    logic [3:0]  settle_cnt;
    logic [15:0] act_q [4];
    logic [15:0] wgt_q [4];
    logic [15:0] result_q;
    logic [15:0] result_d;
    logic        accept;
    logic        settle_done;

    // A word is taken only in LOAD; a simultaneous clear drops it.
    assign accept      = in_valid && in_ready && !clear;
    assign settle_done = (state == SETTLE) && (settle_cnt == SETTLE_LAST);

    // Negative results (sign bit set, including -0, -Inf and negative NaN)
    // become +0 when ReLU is enabled.
    assign result_d = (RELU_EN && mac_result[15]) ? 16'h0000 : mac_result;

    assign mac_in0  = act_q[0];
    assign mac_in1  = act_q[1];
    assign mac_in2  = act_q[2];
    assign mac_in3  = act_q[3];
    assign mac_w0   = wgt_q[0];
    assign mac_w1   = wgt_q[1];
    assign mac_w2   = wgt_q[2];
    assign mac_w3   = wgt_q[3];
    assign out_data = result_q;
    assign busy     = !((state == LOAD) && (word_cnt == 3'd0));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; clear overrides every transition.
    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (word_cnt == 3'd7)) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
        if (clear) begin
            state_nxt = LOAD;
        end
    end

    // Word counter: advances per accepted word and wraps 7 -> 0 at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= 3'd0;
        end else if (clear) begin
            word_cnt <= 3'd0;
        end else if (accept) begin
            word_cnt <= word_cnt + 3'd1;
        end
    end

    // Settle timer: counts SETTLE cycles, idles at zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= 4'd0;
        end else if (clear || (state != SETTLE) || settle_done) begin
            settle_cnt <= 4'd0;
        end else begin
            settle_cnt <= settle_cnt + 4'd1;
        end
    end

    // Operand registers: words 0-3 are activations, 4-7 are weights.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand storage is reset because its contents are driven
        // straight onto the MAC ports, which must read zero during reset.
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                act_q[i] <= 16'h0000;
                wgt_q[i] <= 16'h0000;
            end
        end else if (accept) begin
            if (word_cnt[2]) begin
                wgt_q[word_cnt[1:0]] <= in_data;
            end else begin
                act_q[word_cnt[1:0]] <= in_data;
            end
        end
    end

    // Result register: sampled on the final SETTLE cycle unless aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 16'h0000;
        end else if (settle_done && !clear) begin
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_fp16_mac_feeder.sv
// Self-checking bench for fp16_mac_feeder. Two instances are exercised:
// index 0 with SETTLE_CYCLES=1/RELU_EN=1, index 1 with SETTLE_CYCLES=3/RELU_EN=0.
// A real-arithmetic FP16 MAC model stands in for the external MAC.
`timescale 1ns/1ps

module tb_fp16_mac_feeder;

    logic                  clk;
    logic                  rst_n;
    logic [1:0]            clear;
    logic [1:0]            in_valid;
    logic [1:0]            in_ready;
    logic [1:0]            out_valid;
    logic [1:0]            out_ready;
    logic [1:0]            busy;
    logic [1:0][15:0]      in_data;
    logic [1:0][15:0]      out_data;
    logic [1:0]            ovr_en;
    logic [1:0][15:0]      ovr_val;
    logic [1:0][3:0][15:0] mac_in;
    logic [1:0][3:0][15:0] mac_w;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] fw [8];
    logic [15:0] last_fw [2][8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit relu_of(input int k);
        return (k == 0);
    endfunction

    function automatic real pow2(input int e);
        real p;
        p = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
        else        for (int i = 0; i < -e; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) begin
            m = real'(int'(h[9:0]));
            e = -24;
        end else begin
            m = real'(int'({1'b1, h[9:0]}));
            e = e - 25;
        end
        m = m * pow2(e);
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        logic s;
        real  a;
        int   e;
        int   m;
        s = (x < 0.0);
        a = s ? -x : x;
        if (a == 0.0) return 16'h0000;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > -14) begin a = a * 2.0; e--; end
        if (a < 1.0) begin
            m = $rtoi(a * 1024.0 + 0.5);
            if (m >= 1024) return {s, 5'd1, 10'd0};
            return {s, 5'd0, m[9:0]};
        end
        m = $rtoi((a - 1.0) * 1024.0 + 0.5);
        if (m >= 1024) begin m = 0; e++; end
        if (e > 15) return {s, 5'h1f, 10'd0};
        return {s, 5'(e + 15), m[9:0]};
    endfunction

    function automatic logic [15:0] mac_model(input logic [15:0] a0, a1, a2, a3,
                                              input logic [15:0] w0, w1, w2, w3);
        real acc;
        acc = h2r(a0) * h2r(w0) + h2r(a1) * h2r(w1)
            + h2r(a2) * h2r(w2) + h2r(a3) * h2r(w3);
        return r2h(acc);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mres;

        // External MAC stand-in, optionally overridden with a fixed word.
        always_comb begin
            mres = ovr_en[g] ? ovr_val[g]
                 : mac_model(mac_in[g][0], mac_in[g][1], mac_in[g][2], mac_in[g][3],
                             mac_w[g][0], mac_w[g][1], mac_w[g][2], mac_w[g][3]);
        end

        fp16_mac_feeder #(
            .SETTLE_CYCLES(g == 0 ? 1 : 3),
            .RELU_EN      (g == 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear[g]),
            .in_data   (in_data[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .mac_in0   (mac_in[g][0]),
            .mac_in1   (mac_in[g][1]),
            .mac_in2   (mac_in[g][2]),
            .mac_in3   (mac_in[g][3]),
            .mac_w0    (mac_w[g][0]),
            .mac_w1    (mac_w[g][1]),
            .mac_w2    (mac_w[g][2]),
            .mac_w3    (mac_w[g][3]),
            .mac_result(mres),
            .out_data  (out_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [15:0] rand_word();
        return {1'($urandom), 5'(10 + $urandom % 8), 10'($urandom)};
    endfunction

    task automatic set_frame(input logic [15:0] a, input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            fw[i]     = a;
            fw[4 + i] = w;
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 8; i++) fw[i] = rand_word();
    endtask

    // Expected neuron output from the frame words (or the forced MAC word).
    function automatic logic [15:0] expect_out(input int k);
        logic [15:0] r;
        r = ovr_en[k] ? ovr_val[k]
          : mac_model(fw[0], fw[1], fw[2], fw[3], fw[4], fw[5], fw[6], fw[7]);
        if (relu_of(k) && r[15]) r = 16'h0000;
        return r;
    endfunction

    // Feed fw[] to instance k, then finish per mode:
    // 0 = handshake after 'hold' stalled cycles, 1 = clear with out_ready in OUTPUT,
    // 2 = async reset pulse in OUTPUT. exp_in < 0 selects the model expectation.
    // Starts and ends on a falling edge.
    task automatic run_frame(input int k, input bit throttle, input int hold,
                             input int mode, input int exp_in);
        int          idx;
        int          guard;
        int          c;
        bit          acc;
        bit          tog;
        logic [15:0] exp_v;
        exp_v = (exp_in < 0) ? expect_out(k) : 16'(exp_in);
        idx = 0; guard = 0; tog = 1'b0;
        while (idx < 8 && guard < 64) begin
            acc = 1'b0;
            if (throttle && tog) begin
                in_valid[k] = 1'b0;
            end else begin
                in_valid[k] = 1'b1;
                in_data[k]  = fw[idx];
                acc         = in_ready[k];
            end
            tog = !tog;
            guard++;
            @(negedge clk);
            if (acc) idx++;
        end
        check("frame_accept", idx, 8);
        check("settle_in_ready", in_ready[k], 1'b0);
        check("settle_busy", busy[k], 1'b1);
        c = 1;
        while (!out_valid[k] && c < 40) begin
            in_valid[k] = 1'b1;
            in_data[k]  = 16'($urandom);
            @(negedge clk);
            c++;
        end
        check("latency", c, settle_of(k) + 1);
        check("out_data", out_data[k], exp_v);
        check("out_in_ready", in_ready[k], 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("mac_in", mac_in[k][i], fw[i]);
            check("mac_w", mac_w[k][i], fw[4 + i]);
        end
        for (int i = 0; i < 8; i++) last_fw[k][i] = fw[i];

        if (mode == 1) begin
            clear[k] = 1'b1; out_ready[k] = 1'b1; in_valid[k] = 1'b0;
            @(negedge clk);
            clear[k] = 1'b0; out_ready[k] = 1'b0;
            check("clr_out_valid", out_valid[k], 1'b0);
            check("clr_out_busy", busy[k], 1'b0);
            check("clr_out_in_ready", in_ready[k], 1'b1);
            check("clr_out_result_kept", out_data[k], exp_v);
            return;
        end

        if (mode == 2) begin
            in_valid[k] = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("rst_out_valid", out_valid[k], 1'b0);
            check("rst_in_ready", in_ready[k], 1'b1);
            check("rst_busy", busy[k], 1'b0);
            check("rst_out_data", out_data[k], 16'h0000);
            check("rst_mac_in0", mac_in[k][0], 16'h0000);
            check("rst_mac_w3", mac_w[k][3], 16'h0000);
            in_valid[k] = 1'b1;
            in_data[k]  = 16'h1234;
            #1 rst_n = 1'b1;
            @(negedge clk);
            in_valid[k] = 1'b0;
            check("post_rst_accept_busy", busy[k], 1'b1);
            check("post_rst_accept_data", mac_in[k][0], 16'h1234);
            check("post_rst_no_output", out_valid[k], 1'b0);
            clear[k] = 1'b1;
            @(negedge clk);
            clear[k] = 1'b0;
            check("post_rst_clear_busy", busy[k], 1'b0);
            return;
        end

        for (int h = 0; h < hold; h++) begin
            out_ready[k] = 1'b0;
            in_valid[k]  = 1'b1;
            in_data[k]   = 16'($urandom);
            @(negedge clk);
            check("bp_valid", out_valid[k], 1'b1);
            check("bp_data", out_data[k], exp_v);
            check("bp_in_ready", in_ready[k], 1'b0);
        end
        out_ready[k] = 1'b1;
        in_valid[k]  = 1'b1;
        in_data[k]   = 16'($urandom);
        @(negedge clk);
        out_ready[k] = 1'b0;
        in_valid[k]  = 1'b0;
        check("done_valid", out_valid[k], 1'b0);
        check("done_in_ready", in_ready[k], 1'b1);
        check("done_busy", busy[k], 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; clear = '0; in_valid = '0; out_ready = '0;
        in_data = '0; ovr_en = '0; ovr_val = '0;
        #3;
        for (int k = 0; k < 2; k++) begin
            check("reset_in_ready", in_ready[k], 1'b1);
            check("reset_out_valid", out_valid[k], 1'b0);
            check("reset_busy", busy[k], 1'b0);
            check("reset_out_data", out_data[k], 16'h0000);
            check("reset_mac_in0", mac_in[k][0], 16'h0000);
            check("reset_mac_w3", mac_w[k][3], 16'h0000);
        end
        #9 rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, ReLU on/off, backpressure, throttled input.
        set_frame(16'h3C00, 16'h4000);
        run_frame(0, 1'b0, 0, 0, 16'h4800);
        set_frame(16'h3C00, 16'hC000);
        run_frame(0, 1'b0, 2, 0, 16'h0000);
        run_frame(1, 1'b1, 5, 0, 16'hC800);
        set_frame(16'h3C00, 16'h4000);
        run_frame(1, 1'b1, 0, 0, 16'h4800);

        // Special MAC words through the ReLU stage.
        rand_frame();
        ovr_en[0] = 1'b1;
        ovr_val[0] = 16'h8000; run_frame(0, 1'b0, 0, 0, 16'h0000);
        ovr_val[0] = 16'hFE00; run_frame(0, 1'b0, 0, 0, 16'h0000);
        ovr_val[0] = 16'hFC00; run_frame(0, 1'b0, 0, 0, 16'h0000);
        ovr_val[0] = 16'h7C00; run_frame(0, 1'b0, 0, 0, 16'h7C00);
        ovr_en[0] = 1'b0;
        ovr_en[1] = 1'b1;
        ovr_val[1] = 16'h8000; run_frame(1, 1'b0, 0, 0, 16'h8000);
        ovr_val[1] = 16'hFC00; run_frame(1, 1'b0, 1, 0, 16'hFC00);
        ovr_en[1] = 1'b0;

        // Abort on word 5 with in_valid high.
        rand_frame();
        if (fw[5] == last_fw[0][5]) fw[5] = fw[5] ^ 16'h0001;
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = fw[i];
            @(negedge clk);
        end
        in_valid[0] = 1'b1; in_data[0] = fw[5]; clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0; in_valid[0] = 1'b0;
        check("abort_busy", busy[0], 1'b0);
        check("abort_in_ready", in_ready[0], 1'b1);
        check("abort_w0_loaded", mac_w[0][0], fw[4]);
        check("abort_w1_dropped", mac_w[0][1], last_fw[0][5]);
        rand_frame();
        run_frame(0, 1'b0, 1, 0, -1);

        // Clear coinciding with out_ready in OUTPUT, then a normal frame.
        rand_frame();
        run_frame(1, 1'b0, 0, 1, -1);
        rand_frame();
        run_frame(1, 1'b0, 0, 0, -1);

        // Randomised frames on both instances.
        for (int i = 0; i < 12; i++) begin
            rand_frame();
            run_frame(i % 2, 1'($urandom), int'($urandom % 4), 0, -1);
        end

        // Asynchronous reset while holding a result.
        set_frame(16'h3C00, 16'h4000);
        run_frame(0, 1'b0, 0, 2, 16'h4800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
